// File: rtl/param_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// default geometry and the controller state encoding.
package param_cache_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 32;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_LINES      = 16;
   localparam int DEFAULT_CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      RESP
   } cache_state_e;

endpackage

// File: rtl/param_data_cache_if.sv
// CPU-side and memory-side signal bundle of the data cache; the slave
// modport is the cache itself, the master modport is the CPU/memory side.
interface param_data_cache_if
   import param_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);

   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_ready;
   logic                  cpu_busy;
   logic                  flush;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   logic [CNT_WIDTH-1:0]  hit_count;
   logic [CNT_WIDTH-1:0]  miss_count;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr,
             mem_wdata, hit_count, miss_count
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr,
             mem_wdata, hit_count, miss_count
   );

endinterface

// File: rtl/cache_line_array.sv
// Data, tag and valid storage for the direct-mapped cache: one combinational
// read port, one synchronous write port and a clear-all for the valid bits.
module cache_line_array #(
   parameter int LINES       = 16,
   parameter int INDEX_WIDTH = 4,
   parameter int TAG_WIDTH   = 26,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clear_all,
   input  logic [INDEX_WIDTH-1:0] rd_index,
   output logic                   rd_valid,
   output logic [TAG_WIDTH-1:0]   rd_tag,
   output logic [DATA_WIDTH-1:0]  rd_data,
   input  logic                   wr_en,
   input  logic [INDEX_WIDTH-1:0] wr_index,
   input  logic [TAG_WIDTH-1:0]   wr_tag,
   input  logic [DATA_WIDTH-1:0]  wr_data
);

   logic [LINES-1:0]      valid;
   logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES];

   // Only the valid bits are reset; tag and data are meaningless until valid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
      end else if (clear_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/param_data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache sitting between the CPU datapath and a handshaked backing memory.
module param_data_cache
   import param_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LINES      = DEFAULT_LINES,
   parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
   input  logic              clock,
   input  logic              reset_n,
   param_data_cache_if.slave bus
);

   localparam int INDEX_WIDTH = $clog2(LINES);
   localparam int WORD_WIDTH  = ADDR_WIDTH - 2;
   localparam int TAG_WIDTH   = WORD_WIDTH - INDEX_WIDTH;

   cache_state_e           state;
   logic                   req_we;
   logic [WORD_WIDTH-1:0]  req_word;
   logic [DATA_WIDTH-1:0]  req_wdata;
   logic [INDEX_WIDTH-1:0] req_index;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic                   rd_valid;
   logic [TAG_WIDTH-1:0]   rd_tag;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   hit;
   logic                   clear_all;
   logic                   arr_wr_en;
   logic [DATA_WIDTH-1:0]  arr_wr_data;
   logic                   unused_offset;

   // Byte offset bits never affect a word access.
   assign unused_offset = ^bus.cpu_addr[1:0];

   assign req_index   = req_word[INDEX_WIDTH-1:0];
   assign req_tag     = req_word[WORD_WIDTH-1:INDEX_WIDTH];
   assign hit         = rd_valid && (rd_tag == req_tag);
   assign clear_all   = (state == IDLE) && bus.flush;
   assign arr_wr_en   = ((state == LOOKUP) && req_we && hit) ||
                        ((state == MEM_RD) && bus.mem_ack);
   assign arr_wr_data = (state == MEM_RD) ? bus.mem_rdata : req_wdata;

   cache_line_array #(
      .LINES       (LINES),
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_lines (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear_all (clear_all),
      .rd_index  (req_index),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (arr_wr_en),
      .wr_index  (req_index),
      .wr_tag    (req_tag),
      .wr_data   (arr_wr_data)
   );

   // Controller: every CPU and memory output is a register updated on the
   // transition that enters the state it belongs to.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         req_we         <= 1'b0;
         req_word       <= '0;
         req_wdata      <= '0;
         bus.cpu_rdata  <= '0;
         bus.cpu_ready  <= 1'b0;
         bus.cpu_busy   <= 1'b0;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.hit_count  <= '0;
         bus.miss_count <= '0;
      end else begin
         bus.cpu_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_req && !bus.flush) begin
                  req_we       <= bus.cpu_we;
                  req_word     <= bus.cpu_addr[ADDR_WIDTH-1:2];
                  req_wdata    <= bus.cpu_wdata;
                  bus.cpu_busy <= 1'b1;
                  state        <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (bus.hit_count != {CNT_WIDTH{1'b1}}) begin
                     bus.hit_count <= bus.hit_count + 1'b1;
                  end
               end else if (bus.miss_count != {CNT_WIDTH{1'b1}}) begin
                  bus.miss_count <= bus.miss_count + 1'b1;
               end
               if (!req_we && hit) begin
                  bus.cpu_rdata <= rd_data;
                  bus.cpu_ready <= 1'b1;
                  state         <= RESP;
               end else begin
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= req_we;
                  bus.mem_addr  <= {req_word, 2'b00};
                  bus.mem_wdata <= req_wdata;
                  state         <= req_we ? MEM_WR : MEM_RD;
               end
            end
            MEM_RD, MEM_WR: begin
               if (bus.mem_ack) begin
                  bus.mem_req   <= 1'b0;
                  bus.mem_we    <= 1'b0;
                  bus.cpu_rdata <= (state == MEM_RD) ? bus.mem_rdata : '0;
                  bus.cpu_ready <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               bus.cpu_busy <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_param_data_cache.sv
// Scoreboard bench for param_data_cache: two instances (16-bit and 2-bit
// counters) see identical traffic against a behavioural backing memory.
module tb_param_data_cache;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      bit          chk_lat;
      int          drive_cyc;
   } cpu_exp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   localparam int MEM_WAIT = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic        flush = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit hold_ack = 1'b0;
   bit stray_ack = 1'b0;

   cpu_exp_t    cpu_q [$];
   mem_exp_t    mem_q [$];
   logic [31:0] tb_mem [logic [31:0]];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   param_data_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
   param_data_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(2))  bus_b ();

   assign bus_a.cpu_req   = cpu_req;
   assign bus_a.cpu_we    = cpu_we;
   assign bus_a.cpu_addr  = cpu_addr;
   assign bus_a.cpu_wdata = cpu_wdata;
   assign bus_a.flush     = flush;
   assign bus_a.mem_rdata = mem_rdata;
   assign bus_a.mem_ack   = mem_ack;
   assign bus_b.cpu_req   = cpu_req;
   assign bus_b.cpu_we    = cpu_we;
   assign bus_b.cpu_addr  = cpu_addr;
   assign bus_b.cpu_wdata = cpu_wdata;
   assign bus_b.flush     = flush;
   assign bus_b.mem_rdata = mem_rdata;
   assign bus_b.mem_ack   = mem_ack;

   param_data_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINES(16), .CNT_WIDTH(16)) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_a.slave)
   );

   param_data_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINES(16), .CNT_WIDTH(2)) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_b.slave)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] sat2(input int v);
      return (v > 3) ? 32'd3 : 32'(v);
   endfunction

   task automatic checkCounters(input string name, input int hits, input int misses);
      checkOutput({name, " hit_a"},  32'(bus_a.hit_count),  32'(hits));
      checkOutput({name, " miss_a"}, 32'(bus_a.miss_count), 32'(misses));
      checkOutput({name, " hit_b"},  32'(bus_b.hit_count),  sat2(hits));
      checkOutput({name, " miss_b"}, 32'(bus_b.miss_count), sat2(misses));
   endtask

   task automatic resetDut();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   // One CPU access; hand-computed response and memory traffic go to the queues.
   task automatic applyStimulus(input string name, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit exp_hit,
                                input logic [31:0] exp_mem_addr, input logic [31:0] exp_rdata);
      cpu_exp_t ce;
      mem_exp_t me;
      @(negedge clock);
      checkOutput({name, " idle_busy"}, 32'(bus_a.cpu_busy), 32'd0);
      if (we || !exp_hit) begin
         me.we    = we;
         me.addr  = exp_mem_addr;
         me.wdata = wdata;
         mem_q.push_back(me);
      end
      ce.name      = name;
      ce.rdata     = exp_rdata;
      ce.chk_lat   = exp_hit && !we;
      ce.drive_cyc = cyc;
      cpu_q.push_back(ce);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(negedge clock);
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 32'hFFFF_FFFC;
      cpu_wdata = 32'h0;
      for (int i = 0; i < 100; i++) begin
         if (cpu_q.size() == 0) break;
         @(negedge clock);
      end
      if (cpu_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: cpu_ready not seen, required within 100 cycles", name);
         cpu_q.delete();
      end
      checkOutput({name, " mem_seen"}, 32'(mem_q.size()), 32'd0);
      mem_q.delete();
   endtask

   // Response monitor: pops the oldest expectation whenever cpu_ready shows.
   cpu_exp_t mon_e;
   always @(negedge clock) begin
      if (bus_a.cpu_ready === 1'b1) begin
         if (cpu_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected cpu_ready: actual=1 required=0");
         end else begin
            mon_e = cpu_q.pop_front();
            checkOutput({mon_e.name, " rdata_a"}, bus_a.cpu_rdata, mon_e.rdata);
            checkOutput({mon_e.name, " rdata_b"}, bus_b.cpu_rdata, mon_e.rdata);
            checkOutput({mon_e.name, " ready_b"}, 32'(bus_b.cpu_ready), 32'd1);
            if (mon_e.chk_lat) begin
               checkOutput({mon_e.name, " latency"}, 32'(cyc - mon_e.drive_cyc), 32'd2);
            end
         end
      end
   end

   // Backing memory: checks each request against the queue, then acks.
   initial begin : mem_responder
      mem_exp_t    me;
      logic [31:0] addr_seen;
      bit          we_seen;
      logic [31:0] wdata_seen;
      bit          aborted;
      bit          stable;
      forever begin
         @(negedge clock);
         if (stray_ack) begin
            mem_rdata = 32'h0BAD_0BAD;
            mem_ack   = 1'b1;
            @(negedge clock);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            stray_ack = 1'b0;
         end else if (bus_a.mem_req === 1'b1) begin
            addr_seen  = bus_a.mem_addr;
            we_seen    = bus_a.mem_we;
            wdata_seen = bus_a.mem_wdata;
            if (mem_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected mem_req: actual addr=%h required no request", addr_seen);
            end else begin
               me = mem_q.pop_front();
               checkOutput("mem_addr_a", addr_seen, me.addr);
               checkOutput("mem_addr_b", bus_b.mem_addr, me.addr);
               checkOutput("mem_we", 32'(we_seen), 32'(me.we));
               checkOutput("mem_req_b", 32'(bus_b.mem_req), 32'd1);
               if (me.we) checkOutput("mem_wdata", wdata_seen, me.wdata);
            end
            aborted = 1'b0;
            stable  = 1'b1;
            for (int i = 0; i < MEM_WAIT; i++) begin
               @(negedge clock);
               if (bus_a.mem_req !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (bus_a.mem_addr !== addr_seen) stable = 1'b0;
            end
            for (int i = 0; i < 1000 && hold_ack && !aborted; i++) begin
               @(negedge clock);
               if (bus_a.mem_req !== 1'b1) aborted = 1'b1;
            end
            if (!aborted) begin
               checkOutput("mem_addr stable", 32'(stable), 32'd1);
               if (we_seen) begin
                  tb_mem[addr_seen] = wdata_seen;
               end else begin
                  mem_rdata = tb_mem.exists(addr_seen) ? tb_mem[addr_seen] : 32'h0;
               end
               mem_ack = 1'b1;
               @(negedge clock);
               mem_ack   = 1'b0;
               mem_rdata = '0;
               checkOutput("mem_req drop after ack", 32'(bus_a.mem_req), 32'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      tb_mem[32'h40]  = 32'hDEAD_BEEF;
      tb_mem[32'h44]  = 32'h4444_4444;
      tb_mem[32'h7C]  = 32'h7C7C_7C7C;
      tb_mem[32'h80]  = 32'hCAFE_F00D;
      tb_mem[32'h100] = 32'h0000_0000;

      resetDut();
      checkOutput("reset cpu_ready", 32'(bus_a.cpu_ready), 32'd0);
      checkOutput("reset cpu_busy",  32'(bus_a.cpu_busy),  32'd0);
      checkOutput("reset mem_req",   32'(bus_a.mem_req),   32'd0);
      checkOutput("reset mem_we",    32'(bus_a.mem_we),    32'd0);
      checkOutput("reset mem_addr",  bus_a.mem_addr,       32'd0);
      checkOutput("reset cpu_rdata", bus_a.cpu_rdata,      32'd0);
      checkCounters("reset", 0, 0);

      applyStimulus("rd40 miss", 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 32'hDEAD_BEEF);
      checkCounters("rd40 miss", 0, 1);
      applyStimulus("rd40 hit", 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 32'hDEAD_BEEF);
      checkCounters("rd40 hit", 1, 1);

      resetDut();
      applyStimulus("conflict rd40", 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 32'hDEAD_BEEF);
      applyStimulus("conflict rd80", 1'b0, 32'h80, 32'h0, 1'b0, 32'h80, 32'hCAFE_F00D);
      applyStimulus("conflict rd40 again", 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 32'hDEAD_BEEF);
      checkCounters("conflict", 0, 3);

      applyStimulus("wr40 hit", 1'b1, 32'h40, 32'h1234_5678, 1'b1, 32'h40, 32'h0);
      checkCounters("wr40 hit", 1, 3);
      applyStimulus("rd40 after wr", 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 32'h1234_5678);
      checkCounters("rd40 after wr", 2, 3);
      applyStimulus("wr100 miss", 1'b1, 32'h100, 32'hA5A5_0100, 1'b0, 32'h100, 32'h0);
      checkCounters("wr100 miss", 2, 4);
      applyStimulus("rd100 no alloc", 1'b0, 32'h100, 32'h0, 1'b0, 32'h100, 32'hA5A5_0100);
      checkCounters("rd100 no alloc", 2, 5);
      applyStimulus("rd102 offset hit", 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 32'hA5A5_0100);
      applyStimulus("rd47 align", 1'b0, 32'h47, 32'h0, 1'b0, 32'h44, 32'h4444_4444);
      applyStimulus("rd7C miss", 1'b0, 32'h7C, 32'h0, 1'b0, 32'h7C, 32'h7C7C_7C7C);
      applyStimulus("rd7C hit", 1'b0, 32'h7C, 32'h0, 1'b1, 32'h0, 32'h7C7C_7C7C);
      checkCounters("index edges", 4, 7);

      stray_ack = 1'b1;
      for (int i = 0; i < 20 && stray_ack; i++) @(negedge clock);
      @(negedge clock);
      checkOutput("stray ack busy", 32'(bus_a.cpu_busy), 32'd0);
      checkCounters("stray ack", 4, 7);

      applyStimulus("rd40 refill", 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 32'h1234_5678);
      @(negedge clock);
      cpu_req  = 1'b1;
      cpu_addr = 32'h40;
      flush    = 1'b1;
      @(negedge clock);
      cpu_req  = 1'b0;
      flush    = 1'b0;
      checkOutput("flush beats req busy", 32'(bus_a.cpu_busy), 32'd0);
      applyStimulus("rd40 after flush", 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 32'h1234_5678);
      applyStimulus("rd7C after flush", 1'b0, 32'h7C, 32'h0, 1'b0, 32'h7C, 32'h7C7C_7C7C);
      checkCounters("flush", 4, 10);

      @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      begin
         mem_exp_t me;
         me.we    = 1'b0;
         me.addr  = 32'h40;
         me.wdata = 32'h0;
         mem_q.push_back(me);
      end
      hold_ack = 1'b1;
      cpu_req  = 1'b1;
      cpu_addr = 32'h40;
      @(negedge clock);
      cpu_req  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_a.mem_req === 1'b1) break;
         @(negedge clock);
      end
      @(negedge clock);
      checkOutput("pre-reset mem_req", 32'(bus_a.mem_req), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("mid reset mem_req_a", 32'(bus_a.mem_req),  32'd0);
      checkOutput("mid reset mem_req_b", 32'(bus_b.mem_req),  32'd0);
      checkOutput("mid reset cpu_busy",  32'(bus_a.cpu_busy), 32'd0);
      checkCounters("mid reset", 0, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      hold_ack = 1'b0;
      mem_q.delete();
      applyStimulus("rd40 after reset", 1'b0, 32'h40, 32'h0, 1'b0, 32'h40, 32'h1234_5678);
      checkCounters("rd40 after reset", 0, 1);

      for (int i = 1; i <= 5; i++) begin
         applyStimulus($sformatf("sat hit %0d", i), 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 32'h1234_5678);
         checkCounters($sformatf("sat hit %0d", i), i, 1);
      end

      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_data_cache.md
PARAM_DATA_CACHE -- requirements
Module: param_data_cache

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, is the word width; the only supported value is 32.
REQ-003 Parameter LINES, default 16, is the number of direct-mapped one-word lines; it is a power of 2, minimum 2.
REQ-004 Parameter CNT_WIDTH, default 16, is the width of the hit and miss counters.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cpu_req  in  1  level request from the CPU datapath.
REQ-008 cpu_we  in  1  1 = store (MemWrite), 0 = load (MemRead).
REQ-009 cpu_addr  in  ADDR_WIDTH  byte address (the ALU result).
REQ-010 cpu_wdata  in  DATA_WIDTH  store data (Read_data2).
REQ-011 cpu_rdata  out  DATA_WIDTH  load data; valid while cpu_ready=1.
REQ-012 cpu_ready  out  1  one-cycle completion pulse.
REQ-013 cpu_busy  out  1  1 whenever the state is not IDLE.
REQ-014 flush  in  1  invalidate all lines.
REQ-015 mem_req  out  1  backing-memory request.
REQ-016 mem_we  out  1  backing-memory write enable.
REQ-017 mem_addr  out  ADDR_WIDTH  word-aligned memory address.
REQ-018 mem_wdata  out  DATA_WIDTH  memory write data.
REQ-019 mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ack.
REQ-020 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-021 hit_count, miss_count  out  CNT_WIDTH  saturating statistics counters.

Function
REQ-022 Address split: offset = cpu_addr[1:0] (ignored), index = cpu_addr[2+log2(LINES)-1:2], tag = remaining upper bits.
REQ-023 Policy: write-through, no-write-allocate.
REQ-024 FSM states are IDLE, LOOKUP, MEM_RD, MEM_WR and RESP.
REQ-025 In IDLE, a request is accepted on a cycle with cpu_req=1 and flush=0; cpu_we, cpu_addr and cpu_wdata are registered and the state moves to LOOKUP.
REQ-026 cpu_req is ignored in every state other than IDLE.
REQ-027 In IDLE with flush=1, all valid bits clear in that cycle; flush takes priority over a simultaneous cpu_req, which is not accepted.
REQ-028 LOOKUP, read hit (valid and tag match): go to RESP; hit_count increments.
REQ-029 LOOKUP, read miss: go to MEM_RD; miss_count increments.
REQ-030 LOOKUP, write: go to MEM_WR; on a write hit the line data is updated in this cycle and hit_count increments, otherwise miss_count increments.
REQ-031 MEM_RD and MEM_WR drive mem_req=1, mem_addr={addr[ADDR_WIDTH-1:2],2'b00} and mem_we=0/1 respectively, with mem_wdata = registered store data.
REQ-032 mem_req and mem_addr are held stable until mem_ack; all memory outputs are registered, so mem_req deasserts the cycle after mem_ack.
REQ-033 On mem_ack in MEM_RD, mem_rdata is written to the line, valid is set, the tag is stored and the state moves to RESP.
REQ-034 On mem_ack in MEM_WR, the state moves to RESP with no line update.
REQ-035 RESP asserts cpu_ready=1 for exactly one cycle, with cpu_rdata = line data for loads and 0 for stores, then returns to IDLE.
REQ-036 Read-hit latency is 2 cycles from acceptance to cpu_ready; miss latency is 2 cycles plus memory wait.
REQ-037 mem_ack outside MEM_RD/MEM_WR is ignored.
REQ-038 Counters saturate at all-ones and never wrap.

Reset
REQ-039 reset_n=0 immediately forces state IDLE and clears all valid bits, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata, hit_count and miss_count, including mid-transaction; a transaction in flight is abandoned.
REQ-040 Line data and tag contents are not reset.

Structure
REQ-041 Package param_cache_pkg holds the FSM state enumeration and the default parameter constants.
REQ-042 The data, tag and valid arrays form one sub-module, cache_line_array, with one read port and one write port plus a clear-all-valid input.

Verification (LINES=16)
REQ-043 Reset, then read 0x40 -> mem_req with mem_addr=0x40; ack with 0xDEADBEEF -> cpu_ready, cpu_rdata=0xDEADBEEF, miss_count=1; re-read 0x40 -> no mem_req, cpu_ready 2 cycles after acceptance, hit_count=1.
REQ-044 Read 0x40, read 0x80 (same index 0), read 0x40 -> three memory reads, miss_count=3.
REQ-045 Write 0x12345678 to cached 0x40 -> memory write seen, then read 0x40 hits with 0x12345678; write to uncached 0x100, then read 0x100 -> memory read (no allocate).
REQ-046 Cache 0x40, pulse flush together with cpu_req -> request not accepted; next read 0x40 misses.
REQ-047 Assert reset_n=0 while in MEM_RD -> mem_req and cpu_busy drop immediately, counters are 0, and the next read 0x40 misses.
REQ-048 With CNT_WIDTH=2, 5 read hits -> hit_count=3.
